apb_master_ctrl: RTL and testbench

// APB initiator driving the UART register bank from a simple command/response port.

---
 rtl/apb_master_ctrl_if.sv | 43 ++++
 rtl/apb_master_ctrl.sv | 126 ++++++++++++
 tb/tb_apb_master_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_ctrl_if.sv
// APB initiator bundle: command/response port plus APB request/completion.
// master = initiator view, slave = sequencer/target view.
interface apb_master_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_ctrl.sv
// APB initiator: one command -> one SETUP/ACCESS transfer -> one response.
// Aborts the ACCESS phase after TIMEOUT_CYCLES without PREADY.
module apb_master_ctrl #(
    parameter int APB_ADDR_WIDTH = 8,
    parameter int APB_DATA_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             PCLK,
    input  logic             PRESETN,
    apb_master_ctrl_if.master bus,
    output logic             busy
);
    localparam int AW = APB_ADDR_WIDTH;
    localparam int DW = APB_DATA_WIDTH;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TMO_LAST =
        (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          pwrite_q, pwrite_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic [DW-1:0] pwdata_q, pwdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          tmo_q, tmo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_hit;

    // cnt_q counts completed ACCESS cycles, so this is the last allowed one
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LAST);

    // State register
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.cmd_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (bus.PREADY || tmo_hit) state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, timeout counter and response capture next values
    always_comb begin
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    pwrite_d = bus.cmd_write;
                    paddr_d  = bus.cmd_addr;
                    pwdata_d = bus.cmd_wdata;
                    cnt_d    = '0;
                end
            end
            ACCESS: begin
                if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
                if (bus.PREADY) begin
                    err_d   = bus.PSLVERR;
                    tmo_d   = 1'b0;
                    rdata_d = pwrite_q ? '0 : bus.PRDATA;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs decoded from state; cmd_ready is masked while in reset
    always_comb begin
        bus.cmd_ready   = PRESETN && (state_q == IDLE);
        bus.PSEL        = (state_q == SETUP) || (state_q == ACCESS);
        bus.PENABLE     = (state_q == ACCESS);
        bus.rsp_valid   = (state_q == RESP);
        bus.PWRITE      = pwrite_q;
        bus.PADDR       = paddr_q;
        bus.PWDATA      = pwdata_q;
        bus.rsp_rdata   = rdata_q;
        bus.rsp_err     = err_q;
        bus.rsp_timeout = tmo_q;
        busy            = (state_q != IDLE);
    end
endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed cases then random transfers
// checked against a transaction-level expectation model.
module tb_apb_master_ctrl;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int TMO = 16;

    logic PCLK;
    logic PRESETN;
    logic busy;
    int   total = 0;
    int   bad   = 0;

    apb_master_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    apb_master_ctrl #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .PCLK   (PCLK),
        .PRESETN(PRESETN),
        .bus    (bus.master),
        .busy   (busy)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        int           n_acc;
        logic         err;
        logic         tmo;
        logic [DW-1:0] rdata;
    } exp_t;

    // Expected outcome of one transfer: k = ACCESS cycle carrying PREADY
    function automatic exp_t model(logic w, int k, logic se,
                                   logic [DW-1:0] pr);
        exp_t e;
        if (TMO != 0 && k > TMO) begin
            e.n_acc = TMO;
            e.err   = 1'b1;
            e.tmo   = 1'b1;
            e.rdata = '0;
        end else begin
            e.n_acc = k;
            e.err   = se;
            e.tmo   = 1'b0;
            e.rdata = w ? '0 : pr;
        end
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_slave();
        bus.PREADY  = 1'($urandom);
        bus.PSLVERR = 1'($urandom);
        bus.PRDATA  = DW'($urandom);
    endtask

    task automatic chk_req(string ph, logic w, logic [AW-1:0] a,
                           logic [DW-1:0] d);
        chk({ph, ".PADDR"}, 32'(bus.PADDR), 32'(a));
        chk({ph, ".PWRITE"}, 32'(bus.PWRITE), 32'(w));
        chk({ph, ".PWDATA"}, 32'(bus.PWDATA), 32'(d));
    endtask

    // Entry/exit point: just after a rising edge with the DUT in IDLE
    task automatic xfer(logic w, logic [AW-1:0] a, logic [DW-1:0] d,
                        int k, logic se, logic [DW-1:0] pr, int hold);
        exp_t e;
        e = model(w, k, se, pr);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.rsp_ready = 1'b0;
        rand_slave();
        @(negedge PCLK);
        chk("idle.cmd_ready", 32'(bus.cmd_ready), 1);
        chk("idle.PSEL", 32'(bus.PSEL), 0);
        @(posedge PCLK); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = AW'($urandom);
        bus.cmd_wdata = DW'($urandom);
        rand_slave();
        @(negedge PCLK);
        chk("setup.PSEL", 32'(bus.PSEL), 1);
        chk("setup.PENABLE", 32'(bus.PENABLE), 0);
        chk("setup.cmd_ready", 32'(bus.cmd_ready), 0);
        chk_req("setup", w, a, d);
        @(posedge PCLK); #1;
        for (int i = 1; i <= e.n_acc; i++) begin
            bus.PREADY  = (i == k);
            bus.PSLVERR = (i == k) ? se : 1'($urandom);
            bus.PRDATA  = (i == k) ? pr : DW'($urandom);
            @(negedge PCLK);
            chk("access.PSEL", 32'(bus.PSEL), 1);
            chk("access.PENABLE", 32'(bus.PENABLE), 1);
            chk("access.rsp_valid", 32'(bus.rsp_valid), 0);
            chk_req("access", w, a, d);
            @(posedge PCLK); #1;
        end
        for (int h = 0; h <= hold; h++) begin
            rand_slave();
            if (h < hold) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_addr  = AW'($urandom);
                bus.rsp_ready = 1'b0;
            end else begin
                bus.cmd_valid = 1'b0;
                bus.rsp_ready = 1'b1;
            end
            @(negedge PCLK);
            chk("resp.rsp_valid", 32'(bus.rsp_valid), 1);
            chk("resp.rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
            chk("resp.rsp_err", 32'(bus.rsp_err), 32'(e.err));
            chk("resp.rsp_timeout", 32'(bus.rsp_timeout), 32'(e.tmo));
            chk("resp.PSEL", 32'(bus.PSEL), 0);
            chk("resp.cmd_ready", 32'(bus.cmd_ready), 0);
            @(posedge PCLK); #1;
        end
        bus.rsp_ready = 1'b0;
        rand_slave();
        @(negedge PCLK);
        chk("post.rsp_valid", 32'(bus.rsp_valid), 0);
        chk("post.busy", 32'(busy), 0);
        chk("post.PSEL", 32'(bus.PSEL), 0);
        chk("post.PADDR", 32'(bus.PADDR), 32'(a));
        @(posedge PCLK); #1;
    endtask

    initial begin
        PRESETN       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        bus.PRDATA    = '0;
        #12;
        chk("rst.cmd_ready", 32'(bus.cmd_ready), 0);
        chk("rst.PSEL", 32'(bus.PSEL), 0);
        chk("rst.PENABLE", 32'(bus.PENABLE), 0);
        chk("rst.rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.PADDR", 32'(bus.PADDR), 0);
        chk("rst.PWDATA", 32'(bus.PWDATA), 0);
        chk("rst.rsp_err", 32'(bus.rsp_err), 0);
        @(negedge PCLK);
        PRESETN = 1'b1;
        @(posedge PCLK); #1;

        xfer(1'b1, 8'h30, 8'h03, 2, 1'b0, 8'h5A, 0);
        xfer(1'b0, 8'h50, 8'h00, 1, 1'b0, 8'h0A, 0);
        xfer(1'b1, 8'h50, 8'h11, 1, 1'b1, 8'h77, 0);
        xfer(1'b0, 8'h00, 8'h00, 1, 1'b0, 8'h3C, 0);
        xfer(1'b0, 8'h70, 8'h00, 1000, 1'b0, 8'hFF, 0);
        xfer(1'b0, 8'h24, 8'h00, 3, 1'b0, 8'hC3, 5);
        xfer(1'b0, 8'h25, 8'h00, TMO, 1'b1, 8'h99, 1);

        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h44;
        bus.PREADY    = 1'b0;
        @(posedge PCLK); #1;
        bus.cmd_valid = 1'b0;
        @(posedge PCLK); #3;
        PRESETN = 1'b0;
        #1;
        chk("arst.PSEL", 32'(bus.PSEL), 0);
        chk("arst.PENABLE", 32'(bus.PENABLE), 0);
        chk("arst.rsp_valid", 32'(bus.rsp_valid), 0);
        chk("arst.cmd_ready", 32'(bus.cmd_ready), 0);
        @(negedge PCLK);
        PRESETN = 1'b1;
        @(posedge PCLK); #1;
        @(negedge PCLK);
        chk("arst.post.busy", 32'(busy), 0);
        chk("arst.post.rsp_valid", 32'(bus.rsp_valid), 0);
        chk("arst.post.cmd_ready", 32'(bus.cmd_ready), 1);
        @(posedge PCLK); #1;
        xfer(1'b0, 8'h10, 8'h00, 2, 1'b0, 8'hA5, 0);

        for (int n = 0; n < 40; n++) begin
            xfer(1'($urandom), AW'($urandom), DW'($urandom),
                 int'($urandom_range(1, TMO + 4)), 1'($urandom),
                 DW'($urandom), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
